// File: rtl/ir_meas_sched_if.sv
// Bus between the measurement scheduler and its UART TX / frame parser / display neighbours.
// master = scheduler side, slave = the surrounding frame logic.
interface ir_meas_sched_if;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        frame_valid;
  logic [15:0] frame_temp;
  logic [15:0] temp_out;
  logic        temp_valid;

  modport master (
    output tx_data, tx_start, temp_out, temp_valid,
    input  tx_done, frame_valid, frame_temp
  );

  modport slave (
    input  tx_data, tx_start, temp_out, temp_valid,
    output tx_done, frame_valid, frame_temp
  );
endinterface

// File: rtl/ir_meas_sched.sv
// IR thermometer measurement scheduler: sends the 3-byte query, waits for a decoded frame,
// retries on timeout or sensor fault, and holds the last good temperature.
module ir_meas_sched #(
  parameter int unsigned PERIOD_CYC  = 24000000,
  parameter int unsigned TIMEOUT_CYC = 2400000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter logic [7:0]  CMD_B0      = 8'hA5,
  parameter logic [7:0]  CMD_B1      = 8'h15,
  parameter logic [7:0]  CMD_B2      = 8'hBA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  trig,
  ir_meas_sched_if.master       bus,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            attempt
);

  localparam int unsigned PerW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [PerW-1:0] PerLast   = PerW'(PERIOD_CYC - 1);
  localparam logic [TmoW-1:0] TmoLast   = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [15:0]     FaultCode = 16'hFFFF;

  typedef enum logic [1:0] {StIdle, StSend, StWaitTx, StWaitResp} state_e;

  state_e          state_q, state_d;
  logic [PerW-1:0] per_cnt_q, per_cnt_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      attempt_q, attempt_d;
  logic            pending_q, pending_d;
  logic            err_q, err_d;
  logic            temp_valid_q, temp_valid_d;
  logic [15:0]     temp_q, temp_d;
  logic            tick, req, frame_ok, fail;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      per_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      idx_q        <= '0;
      attempt_q    <= '0;
      pending_q    <= 1'b0;
      err_q        <= 1'b0;
      temp_valid_q <= 1'b0;
      temp_q       <= '0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      idx_q        <= idx_d;
      attempt_q    <= attempt_d;
      pending_q    <= pending_d;
      err_q        <= err_d;
      temp_valid_q <= temp_valid_d;
      temp_q       <= temp_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    idx_d        = idx_q;
    attempt_d    = attempt_q;
    pending_d    = pending_q;
    err_d        = err_q;
    temp_valid_d = 1'b0;
    temp_d       = temp_q;
    tick         = 1'b0;
    fail         = 1'b0;

    if (!en) begin
      per_cnt_d = '0;
    end else if (per_cnt_q == PerLast) begin
      per_cnt_d = '0;
      tick      = 1'b1;
    end else begin
      per_cnt_d = per_cnt_q + 1'b1;
    end

    req      = trig | tick;
    frame_ok = bus.frame_valid && (bus.frame_temp != FaultCode);

    unique case (state_q)
      StIdle: begin
        if (req || pending_q) begin
          state_d   = StSend;
          pending_d = 1'b0;
          attempt_d = '0;
          idx_d     = '0;
        end
      end
      StSend: state_d = StWaitTx;
      StWaitTx: begin
        if (bus.tx_done) begin
          if (idx_q == 2'd2) begin
            idx_d     = '0;
            tmo_cnt_d = '0;
            state_d   = StWaitResp;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StSend;
          end
        end
      end
      StWaitResp: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        // A frame in the timeout cycle still counts; fault code is a failed attempt.
        if (frame_ok) begin
          temp_d       = bus.frame_temp;
          temp_valid_d = 1'b1;
          err_d        = 1'b0;
          state_d      = StIdle;
        end else if (bus.frame_valid || (tmo_cnt_q == TmoLast)) begin
          fail = 1'b1;
        end
        if (fail) begin
          if (32'(attempt_q) < MAX_RETRY) begin
            attempt_d = attempt_q + 1'b1;
            idx_d     = '0;
            state_d   = StSend;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Requests arriving mid-measurement collapse into one pending run.
    if ((state_q != StIdle) && req) pending_d = 1'b1;
  end

  always_comb begin
    bus.tx_start   = (state_q == StSend);
    bus.tx_data    = 8'h00;
    if (state_q == StSend) begin
      case (idx_q)
        2'd0:    bus.tx_data = CMD_B0;
        2'd1:    bus.tx_data = CMD_B1;
        default: bus.tx_data = CMD_B2;
      endcase
    end
    bus.temp_out   = temp_q;
    bus.temp_valid = temp_valid_q;
    busy           = (state_q != StIdle);
    err            = err_q;
    attempt        = attempt_q;
  end

endmodule

// File: tb/tb_ir_meas_sched.sv
// Scoreboard bench for ir_meas_sched: a UART/parser model answers queued responses,
// a monitor pops expected command bytes and temperatures whenever the DUT presents them.
module tb_ir_meas_sched;

  localparam int unsigned PeriodCyc = 1000;
  localparam int unsigned TimeoutCyc = 100;
  localparam int unsigned MaxRetry  = 3;
  localparam int          TxLat     = 20;
  localparam int          RespDelay = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       trig;
  logic       busy;
  logic       err;
  logic [1:0] attempt;

  ir_meas_sched_if bus_if ();

  ir_meas_sched #(
    .PERIOD_CYC  (PeriodCyc),
    .TIMEOUT_CYC (TimeoutCyc),
    .MAX_RETRY   (MaxRetry),
    .CMD_B0      (8'hA5),
    .CMD_B1      (8'h15),
    .CMD_B2      (8'hBA)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .trig    (trig),
    .bus     (bus_if),
    .busy    (busy),
    .err     (err),
    .attempt (attempt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] got;
    logic [31:0] exp;
  } chk_t;

  chk_t        dir_q[$];
  logic [7:0]  exp_tx[$];
  logic [15:0] exp_temp[$];
  logic [15:0] resp_q[$];
  int unsigned start_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          stale_req = 1'b0;

  function automatic void expect_val(input string name, input logic [31:0] got,
                                     input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.got  = got;
    c.exp  = exp;
    dir_q.push_back(c);
  endfunction

  task automatic push_cmd();
    exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'h15);
    exp_tx.push_back(8'hBA);
  endtask

  task automatic pulse_trig();
    @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    expect_val(name, {31'b0, !busy}, 32'd1);
  endtask

  // Monitor: sole owner of the check/error counters.
  initial begin : monitor
    int   tx_idx = 0;
    chk_t c;
    forever begin
      @(negedge clk);
      #1;
      while (dir_q.size() != 0) begin
        c = dir_q.pop_front();
        checks++;
        if (c.got !== c.exp) begin
          errors++;
          $display("FAIL %s: got %0h, required %0h", c.name, c.got, c.exp);
        end
      end
      if (rst) begin
        tx_idx = 0;
      end else if (bus_if.tx_start) begin
        if (tx_idx == 0) start_q.push_back(cyc);
        tx_idx = (tx_idx == 2) ? 0 : tx_idx + 1;
        checks++;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got tx_start with byte %0h, required no tx_start",
                   bus_if.tx_data);
        end else begin
          logic [7:0] eb;
          eb = exp_tx.pop_front();
          if (bus_if.tx_data !== eb) begin
            errors++;
            $display("FAIL tx_byte: got %0h, required %0h", bus_if.tx_data, eb);
          end
        end
      end
      if (!rst && bus_if.temp_valid) begin
        checks++;
        if (exp_temp.size() == 0) begin
          errors++;
          $display("FAIL temp_unexpected: got temp_valid with %0h, required no pulse",
                   bus_if.temp_out);
        end else begin
          logic [15:0] et;
          et = exp_temp.pop_front();
          if (bus_if.temp_out !== et) begin
            errors++;
            $display("FAIL temp_out: got %0h, required %0h", bus_if.temp_out, et);
          end
        end
      end
    end
  end

  // UART TX and frame parser model.
  initial begin : env
    int          tx_cnt = 0;
    int          seq_bytes = 0;
    int          resp_cnt = 0;
    logic [15:0] cur = '0;
    bus_if.tx_done     = 1'b0;
    bus_if.frame_valid = 1'b0;
    bus_if.frame_temp  = '0;
    forever begin
      @(negedge clk);
      #2;
      bus_if.tx_done     = 1'b0;
      bus_if.frame_valid = 1'b0;
      if (rst) begin
        tx_cnt    = 0;
        seq_bytes = 0;
        resp_cnt  = 0;
      end else begin
        if (resp_cnt != 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            bus_if.frame_valid = 1'b1;
            bus_if.frame_temp  = cur;
          end
        end
        if (tx_cnt != 0) begin
          tx_cnt--;
          if (tx_cnt == 0) begin
            bus_if.tx_done = 1'b1;
            seq_bytes++;
            if (seq_bytes == 3) begin
              seq_bytes = 0;
              if (resp_q.size() != 0) begin
                cur      = resp_q.pop_front();
                resp_cnt = RespDelay;
              end
            end
          end
        end
        if (bus_if.tx_start) tx_cnt = TxLat;
        if (stale_req) begin
          bus_if.frame_valid = 1'b1;
          bus_if.frame_temp  = 16'h1234;
          stale_req          = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    rst  = 1'b1;
    en   = 1'b0;
    trig = 1'b0;
    repeat (3) @(negedge clk);
    expect_val("rst_temp_out", bus_if.temp_out, 32'h0);
    expect_val("rst_temp_valid", bus_if.temp_valid, 32'h0);
    expect_val("rst_tx_start", bus_if.tx_start, 32'h0);
    expect_val("rst_tx_data", bus_if.tx_data, 32'h0);
    expect_val("rst_busy", busy, 32'h0);
    expect_val("rst_err", err, 32'h0);
    expect_val("rst_attempt", attempt, 32'h0);
    rst = 1'b0;

    // Single good measurement
    resp_q.push_back(16'h0E2C);
    push_cmd();
    exp_temp.push_back(16'h0E2C);
    pulse_trig();
    expect_val("trig_latency_tx_start", bus_if.tx_start, 32'h1);
    expect_val("busy_after_trig", busy, 32'h1);
    repeat (40) @(negedge clk);
    expect_val("busy_mid_meas", busy, 32'h1);
    wait_idle(500, "t1_idle");
    expect_val("t1_temp_valid", bus_if.temp_valid, 32'h1);
    expect_val("t1_temp_out", bus_if.temp_out, 32'h0E2C);
    expect_val("t1_err", err, 32'h0);
    expect_val("t1_attempt", attempt, 32'h0);

    // No response at all: four full attempts then error
    repeat (4) push_cmd();
    pulse_trig();
    wait_idle(3000, "t2_idle");
    expect_val("t2_temp_valid", bus_if.temp_valid, 32'h0);
    expect_val("t2_err", err, 32'h1);
    expect_val("t2_attempt", attempt, 32'h3);
    expect_val("t2_temp_held", bus_if.temp_out, 32'h0E2C);

    // Fault code then good reading
    resp_q.push_back(16'hFFFF);
    resp_q.push_back(16'h0BB8);
    push_cmd();
    push_cmd();
    exp_temp.push_back(16'h0BB8);
    pulse_trig();
    wait_idle(1000, "t3_idle");
    expect_val("t3_temp_valid", bus_if.temp_valid, 32'h1);
    expect_val("t3_temp_out", bus_if.temp_out, 32'h0BB8);
    expect_val("t3_err", err, 32'h0);
    expect_val("t3_attempt", attempt, 32'h1);

    // Stale frame while idle
    stale_req = 1'b1;
    repeat (3) @(negedge clk);
    expect_val("stale_temp_out", bus_if.temp_out, 32'h0BB8);
    expect_val("stale_busy", busy, 32'h0);

    // Periodic runs plus two collapsed triggers
    start_q.delete();
    for (int i = 0; i < 4; i++) begin
      push_cmd();
      resp_q.push_back(16'h0100 + 16'(i));
      exp_temp.push_back(16'h0100 + 16'(i));
    end
    en = 1'b1;
    n  = 0;
    while (start_q.size() < 2 && n < 2500) begin
      @(negedge clk);
      n++;
    end
    expect_val("per_two_starts", {31'b0, start_q.size() >= 2}, 32'h1);
    repeat (10) @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    repeat (5) @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    n = 0;
    while (start_q.size() < 4 && n < 2500) begin
      @(negedge clk);
      n++;
    end
    expect_val("per_four_starts", {31'b0, start_q.size() >= 4}, 32'h1);
    wait_idle(500, "per_idle");
    en = 1'b0;
    if (start_q.size() >= 4) begin
      expect_val("per_interval_1", start_q[1] - start_q[0], PeriodCyc);
      expect_val("per_interval_2", start_q[3] - start_q[1], PeriodCyc);
      expect_val("trig_extra_follows",
                 {31'b0, (start_q[2] > start_q[1]) && (start_q[2] - start_q[1] < 300)}, 32'h1);
    end
    repeat (1200) @(negedge clk);
    expect_val("no_run_when_disabled", start_q.size(), 32'd4);

    // Reset while waiting on the UART
    exp_tx.push_back(8'hA5);
    pulse_trig();
    repeat (5) @(negedge clk);
    expect_val("busy_wait_tx", busy, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    expect_val("mid_rst_busy", busy, 32'h0);
    expect_val("mid_rst_tx_start", bus_if.tx_start, 32'h0);
    expect_val("mid_rst_tx_data", bus_if.tx_data, 32'h0);
    expect_val("mid_rst_temp_out", bus_if.temp_out, 32'h0);
    expect_val("mid_rst_temp_valid", bus_if.temp_valid, 32'h0);
    expect_val("mid_rst_err", err, 32'h0);
    expect_val("mid_rst_attempt", attempt, 32'h0);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    expect_val("post_rst_idle", busy, 32'h0);

    expect_val("exp_tx_drained", exp_tx.size(), 32'd0);
    expect_val("exp_temp_drained", exp_temp.size(), 32'd0);
    expect_val("resp_drained", resp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_meas_sched.md
Name: ir_meas_sched

Overview:
- Measurement scheduler for the IR thermometer path.
- Sequences each reading: sends a 3-byte query command to the sensor via a UART transmitter, then waits for the frame parser to report a decoded 16-bit temperature.
- Applies timeout/retry and latches the last good temperature for the binary-to-BCD/display stage.
- Runs periodically when enabled, or on single-shot trigger; sits between the UART TX/RX frame logic and the BCD converter.

Parameters:
- PERIOD_CYC, 24000000, cycles between automatic measurements (1 s at 24 MHz)
- TIMEOUT_CYC, 2400000, max cycles waiting for a response frame after the last command byte
- MAX_RETRY, 3, extra attempts after the first failure before flagging error
- CMD_B0, 8'hA5, command byte 0
- CMD_B1, 8'h15, command byte 1
- CMD_B2, 8'hBA, command byte 2

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  periodic measurement enable
- trig  in  1  single-shot request, 1-cycle pulse
- tx_data  out  8  command byte to UART TX, valid with tx_start
- tx_start  out  1  1-cycle pulse: load tx_data into UART TX
- tx_done  in  1  1-cycle pulse: UART TX finished current byte
- frame_valid  in  1  1-cycle pulse: parser has a complete temperature frame
- frame_temp  in  16  decoded temperature, valid with frame_valid
- temp_out  out  16  last good temperature, held
- temp_valid  out  1  1-cycle pulse when temp_out updates
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky: all attempts failed; cleared by next good reading
- attempt  out  2  retries used in current/last measurement

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; temp_out 0, temp_valid 0, tx_start 0, tx_data 0, busy 0, err 0, attempt 0; pending flag, byte index, period and timeout counters all 0.
- Reset mid-operation aborts the measurement. No tx_start is issued after rst is sampled high.
- States: IDLE, SEND, WAIT_TX, WAIT_RESP.
- Period counter:
  - Counts while en=1 and clears to 0 while en=0.
  - At PERIOD_CYC-1 it wraps to 0 and raises a request.
- Request sources: trig or a period tick.
  - In IDLE, a request moves the state to SEND at the next edge.
  - In any other state, a request sets the single pending flag. Multiple requests collapse into one.
  - In IDLE with pending=1, the pending flag is cleared and the state moves to SEND.
- SEND:
  - tx_start=1 for exactly one cycle, with tx_data = CMD_B[idx].
  - Next state WAIT_TX.
- WAIT_TX:
  - On tx_done: if idx<2, idx++ and go to SEND; if idx==2, idx=0, clear the timeout counter and go to WAIT_RESP.
  - No timeout in WAIT_TX.
- WAIT_RESP: timeout counter increments every cycle.
  - frame_valid with frame_temp != 16'hFFFF: temp_out <= frame_temp; temp_valid=1 in the following cycle; err <= 0; go to IDLE.
  - frame_valid with frame_temp == 16'hFFFF (sensor fault code): counts as a failed attempt, handled immediately.
  - Counter reaching TIMEOUT_CYC-1 is a failed attempt.
  - If frame_valid and timeout occur in the same cycle, frame_valid wins.
- Failed attempt:
  - If attempt < MAX_RETRY: attempt++, idx=0, go to SEND.
  - Otherwise: err <= 1, go to IDLE; temp_out is unchanged and there is no temp_valid pulse.
- attempt resets to 0 at the start of each new measurement (IDLE to SEND). It holds its final value while in IDLE.
- Ignored inputs:
  - frame_valid outside WAIT_RESP is ignored (stale frames are not latched).
  - tx_done outside WAIT_TX is ignored.
- Latency:
  - trig sampled in IDLE at edge k: tx_start high in cycle k+1.
  - Accepted frame_valid at edge k: temp_out/temp_valid in cycle k+1, busy low in cycle k+1.
- Widths: all counters are sized by $clog2 of their parameter. There is no arithmetic on temperature data; it passes through unchanged.

Test Plan:
- Reset then trig; TX model returns tx_done 20 cycles after each tx_start -> tx_data sequence A5,15,BA; one tx_start per byte; busy=1 until a response arrives.
- After the third tx_done, frame_valid with frame_temp=16'h0E2C -> temp_out=16'h0E2C and temp_valid pulse in the next cycle; busy=0; err=0; attempt=0.
- No response, TIMEOUT_CYC=100, MAX_RETRY=3 -> 4 full command sequences; err=1 after the 4th timeout; temp_out keeps its previous value; attempt=3.
- First response 16'hFFFF, second 16'h0BB8 -> one retry, attempt=1, temp_out=16'h0BB8, err cleared.
- en=1, PERIOD_CYC=1000, immediate responses -> measurements start every 1000 cycles. trig pulsed twice mid-measurement -> exactly one extra measurement follows.
- rst asserted in WAIT_TX -> next cycle all outputs at reset values; no further tx_start. frame_valid while IDLE -> temp_out unchanged.
